// File: rtl/change_dispenser_pkg.sv
// Shared vending types for the change payout path: FSM states, coin encoding and coin values.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        GAP,
        DONE,
        JAM
    } state_t;

    typedef enum logic {
        NICKEL = 1'b0,
        DIME   = 1'b1
    } coin_t;

    localparam int unsigned NICKEL_UNITS = 1;
    localparam int unsigned DIME_UNITS   = 2;

    // Value of one coin in nickel units
    function automatic int unsigned coin_units(input coin_t coin);
        return (coin == DIME) ? DIME_UNITS : NICKEL_UNITS;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory_counter.sv
// Saturating inventory counter: +1 per load pulse (clipped at all-ones), -1 per dispensed coin.
module coin_inventory_counter #(
    parameter int unsigned W    = 8,
    parameter int unsigned INIT = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    output logic [W-1:0] count
);

    logic [W-1:0] count_inc;
    logic [W-1:0] count_n;

    // Saturate first, then decrement: a simultaneous load and dec at all-ones nets to -1
    always_comb begin
        count_inc = count;
        if (load && (count != {W{1'b1}})) begin
            count_inc = count + W'(1);
        end
        count_n = dec ? (count_inc - W'(1)) : count_inc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= W'(INIT);
        end else begin
            count <= count_n;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: greedy dime-first ejects confirmed by the hopper sensor, with jam timeout and inventory.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W        = 5,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned INIT_NICKELS = 0,
    parameter int unsigned INIT_DIMES   = 0,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_nickel,
    input  logic             load_dime,
    input  logic             coin_sensed,
    input  logic             clear_jam,
    output logic             nickel_eject,
    output logic             dime_eject,
    output logic             done,
    output logic             short_flag,
    output logic [AMT_W-1:0] shortfall,
    output logic             jam,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES) + 1;

    state_t             state, state_n;
    coin_t              coin, coin_n;
    logic [AMT_W-1:0]   remaining, remaining_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic               dec_nickel_c;
    logic               dec_dime_c;

    coin_inventory_counter #(
        .W    (CNT_W),
        .INIT (INIT_NICKELS)
    ) u_nickel_inv (
        .clock (clock),
        .reset (reset),
        .load  (load_nickel),
        .dec   (dec_nickel_c),
        .count (nickel_count)
    );

    coin_inventory_counter #(
        .W    (CNT_W),
        .INIT (INIT_DIMES)
    ) u_dime_inv (
        .clock (clock),
        .reset (reset),
        .load  (load_dime),
        .dec   (dec_dime_c),
        .count (dime_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            coin      <= NICKEL;
            remaining <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            coin      <= coin_n;
            remaining <= remaining_n;
            timer     <= timer_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        coin_n       = coin;
        remaining_n  = remaining;
        timer_n      = timer;
        gap_cnt_n    = gap_cnt;
        dec_nickel_c = 1'b0;
        dec_dime_c   = 1'b0;

        unique case (state)
            IDLE: begin
                // Accept only once the registered ready is visible to the requester
                if (req_valid && req_ready) begin
                    remaining_n = req_amount;
                    state_n     = (req_amount == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                timer_n = '0;
                if ((remaining >= AMT_W'(DIME_UNITS)) && (dime_count != '0)) begin
                    coin_n  = DIME;
                    state_n = EJECT;
                end else if ((remaining >= AMT_W'(NICKEL_UNITS)) && (nickel_count != '0)) begin
                    coin_n  = NICKEL;
                    state_n = EJECT;
                end else begin
                    state_n = DONE;
                end
            end
            EJECT: begin
                // A sensed coin wins over a same-cycle timeout
                if (coin_sensed) begin
                    dec_dime_c   = (coin == DIME);
                    dec_nickel_c = (coin == NICKEL);
                    remaining_n  = remaining - AMT_W'(coin_units(coin));
                    gap_cnt_n    = '0;
                    state_n      = GAP;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    state_n = JAM;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_n = SELECT;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            JAM: begin
                if (clear_jam) begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs follow the current state one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready    <= 1'b1;
            nickel_eject <= 1'b0;
            dime_eject   <= 1'b0;
            done         <= 1'b0;
            short_flag   <= 1'b0;
            shortfall    <= '0;
            jam          <= 1'b0;
        end else begin
            req_ready    <= (state == IDLE);
            nickel_eject <= (state == EJECT) && (coin == NICKEL);
            dime_eject   <= (state == EJECT) && (coin == DIME);
            done         <= (state == DONE);
            jam          <= (state == JAM);
            if (state == DONE) begin
                shortfall  <= remaining;
                short_flag <= (remaining != '0);
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout sequences, shortfall, jam, restock netting and reset abort.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [4:0] req_amount;
    logic       req_ready;
    logic       load_nickel;
    logic       load_dime;
    logic       coin_sensed;
    logic       clear_jam;
    logic       nickel_eject;
    logic       dime_eject;
    logic       done;
    logic       short_flag;
    logic [4:0] shortfall;
    logic       jam;
    logic [7:0] nickel_count;
    logic [7:0] dime_count;

    int n_vec = 0;
    int n_err = 0;

    int seq, lat, ej_total;
    bit got_done, got_jam, both_hi, seen;

    change_dispenser dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .load_nickel  (load_nickel),
        .load_dime    (load_dime),
        .coin_sensed  (coin_sensed),
        .clear_jam    (clear_jam),
        .nickel_eject (nickel_eject),
        .dime_eject   (dime_eject),
        .done         (done),
        .short_flag   (short_flag),
        .shortfall    (shortfall),
        .jam          (jam),
        .nickel_count (nickel_count),
        .dime_count   (dime_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_coins(input int n_nick, input int n_dime);
        int n;
        n = (n_nick > n_dime) ? n_nick : n_dime;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            load_nickel = (i < n_nick);
            load_dime   = (i < n_dime);
        end
        @(negedge clock);
        load_nickel = 1'b0;
        load_dime   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Issue a request and play the hopper: sense the coin sense_after cycles into each eject
    task automatic run_req(input logic [4:0] amount, input int sense_after, input bit load_on_sense,
                           output int o_seq, output int o_lat, output bit o_done, output bit o_jam,
                           output int o_ej, output bit o_both);
        int run;
        o_seq = 0; o_lat = 0; o_done = 0; o_jam = 0; o_ej = 0; o_both = 0; run = 0;
        @(negedge clock);
        check("ready_at_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_amount = amount;
        @(negedge clock);
        req_valid  = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) @(negedge clock);
            coin_sensed = 1'b0;
            load_nickel = 1'b0;
            load_dime   = 1'b0;
            if (dime_eject && nickel_eject) o_both = 1'b1;
            if (done) begin
                o_done = 1'b1;
                o_lat  = i;
                break;
            end
            if (jam) begin
                o_jam = 1'b1;
                break;
            end
            if (dime_eject || nickel_eject) begin
                run++;
                o_ej++;
                if (run == sense_after) begin
                    coin_sensed = 1'b1;
                    o_seq = o_seq * 10 + (dime_eject ? 2 : 1);
                    if (load_on_sense) begin
                        load_dime   = dime_eject;
                        load_nickel = nickel_eject;
                    end
                end
            end else begin
                run = 0;
            end
        end
        coin_sensed = 1'b0;
        load_nickel = 1'b0;
        load_dime   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_amount = '0; load_nickel = 1'b0;
        load_dime = 1'b0; coin_sensed = 1'b0; clear_jam = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_ejects", 32'({nickel_eject, dime_eject}), 32'd0);
        check("rst_done_jam", 32'({done, jam, short_flag}), 32'd0);
        check("rst_shortfall", 32'(shortfall), 32'd0);
        check("rst_counts", 32'({nickel_count, dime_count}), 32'd0);

        // Full payout of 25 cents from 5/5
        load_coins(5, 5);
        check("load_counts", 32'({nickel_count, dime_count}), 32'h0505);
        run_req(5'd5, 3, 1'b0, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t1_done", 32'(got_done), 32'd1);
        check("t1_seq", 32'(seq), 32'd221);
        check("t1_short", 32'(short_flag), 32'd0);
        check("t1_shortfall", 32'(shortfall), 32'd0);
        check("t1_nickels", 32'(nickel_count), 32'd4);
        check("t1_dimes", 32'(dime_count), 32'd3);
        check("t1_onehot", 32'(both_hi), 32'd0);
        @(negedge clock);
        check("t1_done_pulse", 32'(done), 32'd0);
        wait_ready("t1_ready_back");

        // No dimes, 3 nickels, 20 cents owed
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        load_coins(3, 0);
        run_req(5'd4, 3, 1'b0, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t2_done", 32'(got_done), 32'd1);
        check("t2_seq", 32'(seq), 32'd111);
        check("t2_short", 32'(short_flag), 32'd1);
        check("t2_shortfall", 32'(shortfall), 32'd1);
        check("t2_nickels", 32'(nickel_count), 32'd0);
        wait_ready("t2_ready_back");

        // Zero amount: done two cycles after acceptance, no coins
        run_req(5'd0, 3, 1'b0, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t3_latency", 32'(lat), 32'd2);
        check("t3_ejects", 32'(ej_total), 32'd0);
        check("t3_short", 32'(short_flag), 32'd0);
        wait_ready("t3_ready_back");

        // Jam: sensor never fires
        load_coins(0, 2);
        run_req(5'd3, 0, 1'b0, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t4_jam_seen", 32'(got_jam), 32'd1);
        check("t4_eject_len", 32'(ej_total), 32'd16);
        check("t4_ready_low", 32'(req_ready), 32'd0);
        check("t4_ejects_low", 32'({nickel_eject, dime_eject}), 32'd0);
        @(negedge clock);
        clear_jam = 1'b1;
        @(negedge clock);
        clear_jam = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("t4_done", 32'(seen), 32'd1);
        check("t4_jam_clear", 32'(jam), 32'd0);
        check("t4_shortfall", 32'(shortfall), 32'd3);
        check("t4_short", 32'(short_flag), 32'd1);
        check("t4_dimes", 32'(dime_count), 32'd2);
        wait_ready("t4_ready_back");

        // Restock in the same cycle as a dispensed dime nets to zero
        run_req(5'd2, 3, 1'b1, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t5_seq", 32'(seq), 32'd2);
        check("t5_dimes", 32'(dime_count), 32'd2);
        wait_ready("t5_ready_back");

        // Saturation, then net load+dec at all-ones
        load_coins(260, 0);
        check("t5_sat", 32'(nickel_count), 32'd255);
        load_coins(1, 0);
        check("t5_sat_hold", 32'(nickel_count), 32'd255);
        run_req(5'd1, 2, 1'b1, seq, lat, got_done, got_jam, ej_total, both_hi);
        check("t5_seq_n", 32'(seq), 32'd1);
        check("t5_sat_net", 32'(nickel_count), 32'd254);
        wait_ready("t5b_ready_back");

        // Sensor pulse outside EJECT is ignored
        @(negedge clock);
        coin_sensed = 1'b1;
        @(negedge clock);
        coin_sensed = 1'b0;
        @(negedge clock);
        check("idle_sense", 32'({nickel_count, dime_count}), 32'hFE02);

        // Reset while a dime is being ejected
        @(negedge clock);
        req_valid  = 1'b1;
        req_amount = 5'd2;
        @(negedge clock);
        req_valid  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dime_eject) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("t6_eject_seen", 32'(seen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_ejects", 32'({nickel_eject, dime_eject}), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_counts", 32'({nickel_count, dime_count}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done || dime_eject || nickel_eject) seen = 1'b1;
        end
        check("t6_no_done", 32'(seen), 32'd0);
        check("t6_ready_after", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
